// File: rtl/spart_rx.sv
// ---------------------------------------------------------------------------
// spart_rx -- SPART UART receiver.
//
// Oversamples rxd at 16x the bit rate, frames 8N1 characters (LSB first) and
// presents each good byte on databus with a level-held rda flag. The
// consumer acknowledges with a one-cycle rd_ack pulse, which also clears the
// sticky error flags.
//
// Optional feature: define SPART_PARITY_EN to receive 8E1 frames. An even
// parity bit then sits between the data and the stop bit, and a mismatch
// sets parity_err. Without the macro, parity_err is tied to 0.
//
// Parameters
//   DIVISOR     clk cycles per 16x oversample tick (2..65535)
//   CNT_W       width of the baud divisor counter
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   rxd         asynchronous serial input, idle high
//   rd_ack      one-cycle acknowledge; clears rda and the sticky flags
//   databus     last correctly framed byte
//   rda         receive data available (level, held until rd_ack)
//   overrun     sticky: a byte completed while rda was already set
//   frame_err   sticky: stop bit sampled low
//   parity_err  sticky: even parity mismatch (SPART_PARITY_EN only)
// ---------------------------------------------------------------------------
module spart_rx #(
    parameter int DIVISOR = 326,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd_ack,
    output logic [7:0] databus,
    output logic       rda,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIVISOR - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SPART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizer. Resets high so a reset does not look like a start.
    // -----------------------------------------------------------------------
    logic rxd_m;
    logic rxd_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // -----------------------------------------------------------------------
    // Receive FSM, baud divisor and bit/sample counters.
    // -----------------------------------------------------------------------
    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic             tick;
    logic [3:0]       smp_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    // armed: the line has been seen high on a tick since the last frame.
    // Blocks a held-low break from retriggering start detection.
    logic             armed;
    // One-cycle completion pulses, consumed by the output register block.
    logic             done_ok;
    logic             done_ferr;
`ifdef SPART_PARITY_EN
    logic             par_bit;
    logic             done_perr;
`endif

    assign tick = (baud_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= RELOAD;
            smp_cnt   <= 4'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            armed     <= 1'b0;
            done_ok   <= 1'b0;
            done_ferr <= 1'b0;
`ifdef SPART_PARITY_EN
            par_bit   <= 1'b0;
            done_perr <= 1'b0;
`endif
        end else begin
            done_ok   <= 1'b0;
            done_ferr <= 1'b0;
`ifdef SPART_PARITY_EN
            done_perr <= 1'b0;
`endif
            // Free-running divisor; overridden below on a start edge.
            baud_cnt <= tick ? RELOAD : baud_cnt - CNT_W'(1);

            case (state)
                IDLE: begin
                    if (tick && rxd_s)
                        armed <= 1'b1;
                    if (armed && !rxd_s) begin
                        // Phase-lock the oversampler to the start edge:
                        // first tick lands on the next clk.
                        state    <= START;
                        baud_cnt <= '0;
                        smp_cnt  <= 4'd0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (smp_cnt == 4'd7) begin
                            // Mid start bit: a high line means a glitch.
                            if (rxd_s) begin
                                state <= IDLE;
                                armed <= 1'b1;
                            end else begin
                                state   <= DATA;
                                smp_cnt <= 4'd0;
                                bit_cnt <= 3'd0;
                            end
                        end else begin
                            smp_cnt <= smp_cnt + 4'd1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        smp_cnt <= smp_cnt + 4'd1;
                        if (smp_cnt == 4'd15) begin
                            shift   <= {rxd_s, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
`ifdef SPART_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
                    end
                end

`ifdef SPART_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        smp_cnt <= smp_cnt + 4'd1;
                        if (smp_cnt == 4'd15) begin
                            par_bit <= rxd_s;
                            state   <= STOP;
                        end
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        smp_cnt <= smp_cnt + 4'd1;
                        if (smp_cnt == 4'd15) begin
                            state     <= IDLE;
                            // A good stop bit already counts as line-high,
                            // so a back-to-back start is accepted at once.
                            armed     <= rxd_s;
                            done_ok   <= rxd_s;
                            done_ferr <= ~rxd_s;
`ifdef SPART_PARITY_EN
                            done_perr <= par_bit ^ (^shift);
`endif
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Host-facing registers. rd_ack clears first; a completion in the same
    // cycle then overrides, so the new byte and its own errors always win.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            databus   <= 8'h00;
            rda       <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rd_ack) begin
                rda       <= 1'b0;
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (done_ok) begin
                databus <= shift;
                rda     <= 1'b1;
                if (rda && !rd_ack)
                    overrun <= 1'b1;
            end
            if (done_ferr)
                frame_err <= 1'b1;
        end
    end

`ifdef SPART_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            parity_err <= 1'b0;
        else if (done_perr)
            parity_err <= 1'b1;
        else if (rd_ack)
            parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx.sv
// ---------------------------------------------------------------------------
// tb_spart_rx -- self-checking bench for spart_rx (DIVISOR = 4).
//
// A reference model predicts the host-facing outputs every cycle. Each
// transmitted frame schedules a completion event at the cycle where rda
// (or an error flag) must change, computed from the frame timing: 2-flop
// sync, start detect, 8 ticks to mid start bit, 16 ticks per later bit,
// plus one register stage. rd_ack and rst are applied by the flag rules.
// ---------------------------------------------------------------------------
module tb_spart_rx;

    localparam int D   = 4;
    localparam int BIT = 16 * D;
`ifdef SPART_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Cycles from driving the start bit to the first cycle rda reflects it.
    localparam int LAT = 5 + 7 * D + 16 * D * (9 + PAR);

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       rxd    = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] databus;
    logic       rda;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;

    spart_rx #(.DIVISOR(D), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rd_ack     (rd_ack),
        .databus    (databus),
        .rda        (rda),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         c;
        logic [7:0] d;
        bit         ok;
        bit         pbad;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] m_db  = 8'h00;
    bit         m_rda = 1'b0;
    bit         m_ov  = 1'b0;
    bit         m_fe  = 1'b0;
    bit         m_pe  = 1'b0;

    initial begin
        bit  rst_prev = 1'b1;
        bit  ack_prev = 1'b0;
        bit  old_rda;
        ev_t ev;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                m_db = 8'h00; m_rda = 0; m_ov = 0; m_fe = 0; m_pe = 0;
                evq.delete();
            end else begin
                old_rda = m_rda;
                if (ack_prev) begin
                    m_rda = 0; m_ov = 0; m_fe = 0; m_pe = 0;
                end
                while (evq.size() > 0 && evq[0].c < cyc)
                    void'(evq.pop_front());
                if (evq.size() > 0 && evq[0].c == cyc) begin
                    ev = evq.pop_front();
                    if (ev.ok) begin
                        m_db  = ev.d;
                        m_rda = 1;
                        if (old_rda && !ack_prev)
                            m_ov = 1;
                    end else begin
                        m_fe = 1;
                    end
                    if (ev.pbad)
                        m_pe = 1;
                end
            end
            rst_prev = rst;
            ack_prev = rd_ack;
            chk("outs", 32'({databus, rda, overrun, frame_err, parity_err}),
                        32'({m_db, m_rda, m_ov, m_fe, m_pe}));
        end
    end

    // ---------------- stimulus helpers (all end at posedge+1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_bad);
        logic frame_bits [0:10];
        int   nb;
        ev_t  ev;
        nb = 10 + PAR;
        frame_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame_bits[1 + i] = d[i];
        if (PAR == 1) frame_bits[9] = (^d) ^ par_bad;
        frame_bits[9 + PAR] = stop_bit;
        ev.c = cyc + LAT; ev.d = d; ev.ok = stop_bit; ev.pbad = (PAR == 1) && par_bad;
        evq.push_back(ev);
        for (int i = 0; i < nb; i++) begin
            rxd = frame_bits[i];
            idle(BIT);
        end
        rxd = 1'b1;
    endtask

    task automatic ack_at(input int c);
        while (cyc < c - 1) idle(1);
        rd_ack = 1'b1;
        idle(1);
        rd_ack = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         s;
        logic [7:0] d;
        bit         stop_ok;
        bit         pb;
        int         mode;
        int         off;

        idle(4);
        rst = 1'b0;
        idle(10 * D);
        chk("reset_databus", 32'(databus), 32'h00);
        chk("reset_rda", 32'(rda), 32'h0);
        chk("reset_flags", 32'({overrun, frame_err, parity_err}), 32'h0);

        // single byte, then acknowledge
        send_frame(8'h77, 1'b1, 1'b0);
        chk("w_rda", 32'(rda), 32'h1);
        chk("w_databus", 32'(databus), 32'h77);
        ack_at(cyc + 1);
        idle(1);
        chk("w_ack_rda", 32'(rda), 32'h0);
        chk("w_ack_hold", 32'(databus), 32'h77);
        idle(2 * D);

        // overrun: two bytes without an acknowledge
        send_frame(8'h4A, 1'b1, 1'b0);
        idle(D);
        send_frame(8'h61, 1'b1, 1'b0);
        chk("ovr_databus", 32'(databus), 32'h61);
        chk("ovr_flag", 32'({rda, overrun}), 32'h3);
        ack_at(cyc + 1);
        idle(1);
        chk("ovr_cleared", 32'({rda, overrun}), 32'h0);

        // 16-clk glitch is a false start, then a real byte
        idle(2 * D);
        rxd = 1'b0;
        idle(16);
        rxd = 1'b1;
        idle(2 * BIT);
        chk("glitch_quiet", 32'({rda, overrun, frame_err}), 32'h0);
        send_frame(8'h53, 1'b1, 1'b0);
        chk("s_databus", 32'(databus), 32'h53);
        ack_at(cyc + 1);
        idle(2 * D);

        // bad stop bit
        send_frame(8'h64, 1'b0, 1'b0);
        chk("ferr_flag", 32'({rda, frame_err}), 32'h1);
        chk("ferr_hold", 32'(databus), 32'h53);
        idle(4 * D);

        // reset in the middle of the next frame, then a clean byte
        rxd = 1'b0;
        idle(BIT);
        rxd = 1'b1;
        idle(BIT);
        rxd = 1'b0;
        idle(BIT);
        rst = 1'b1;
        rxd = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("midrst_outs", 32'({databus, rda, overrun, frame_err, parity_err}), 32'h0);
        idle(10 * D);
        send_frame(8'h44, 1'b1, 1'b0);
        chk("d_databus", 32'(databus), 32'h44);

        // completion coincident with rd_ack while rda already set
        idle(D);
        s = cyc;
        fork
            send_frame(8'h6A, 1'b1, 1'b0);
            ack_at(s + LAT);
        join
        chk("coinc_rda_ovr", 32'({rda, overrun}), 32'h2);
        chk("coinc_databus", 32'(databus), 32'h6A);

        // break: one frame_err, no retrigger while held low
        ack_at(cyc + 1);
        idle(2 * D);
        s = cyc;
        fork
            begin
                send_frame(8'h00, 1'b0, 1'b0);
                rxd = 1'b0;
                idle(3 * BIT * 10);
                rxd = 1'b1;
            end
            ack_at(s + LAT + 10);
        join
        chk("break_once", 32'({rda, frame_err}), 32'h0);
        idle(4 * D);

`ifdef SPART_PARITY_EN
        send_frame(8'h73, 1'b1, 1'b0);
        chk("par_good", 32'({databus, rda, parity_err}), 32'({8'h73, 1'b1, 1'b0}));
        ack_at(cyc + 1);
        idle(2 * D);
        send_frame(8'h73, 1'b1, 1'b1);
        chk("par_bad", 32'({databus, rda, parity_err}), 32'({8'h73, 1'b1, 1'b1}));
        ack_at(cyc + 1);
        idle(2 * D);
`endif

        // randomized frames, gaps and acknowledges
        for (int i = 0; i < 24; i++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom % 8) != 0;
            pb      = (PAR == 1) && (($urandom % 4) == 0);
            mode    = int'($urandom % 3);
            s       = cyc;
            if (mode == 0) begin
                send_frame(d, stop_ok, pb);
            end else if (mode == 1) begin
                off = int'($urandom_range(0, 2)) - 1;
                fork
                    send_frame(d, stop_ok, pb);
                    ack_at(s + LAT + off);
                join
            end else begin
                off = int'($urandom_range(20, LAT - 20));
                fork
                    send_frame(d, stop_ok, pb);
                    ack_at(s + off);
                join
            end
            if (!stop_ok)
                idle(4 * D + int'($urandom % BIT));
            else
                idle((($urandom % 3) == 0) ? 0 : int'($urandom % BIT));
        end

        idle(2 * BIT);
        chk("drain", 32'(evq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- UART receive stage of the SPART; sits directly upstream of the keyboard-to-CPU decode stage.
- Oversamples the serial line at 16x, frames 8N1 characters (LSB first) and presents each byte on databus with a level-held rda flag.
- Downstream edge-detects rda, decodes WASDJ keys and acknowledges with rd_ack so rda falls before the next byte.

Parameters:
- DIVISOR, 326, clk cycles per 16x oversample tick (50 MHz / (9600*16) ≈ 326); legal range 2..65535.
- CNT_W, 16, width of the baud divisor counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- rxd  input  1  asynchronous serial input; idle high.
- rd_ack  input  1  one-cycle pulse from the consumer; clears rda, overrun, frame_err, parity_err.
- databus  output  8  last correctly framed byte.
- rda  output  1  receive data available; level, held until rd_ack.
- overrun  output  1  sticky; a new byte arrived while rda was already 1.
- frame_err  output  1  sticky; stop bit sampled low.
- parity_err  output  1  sticky; parity mismatch. Tied 0 unless SPART_PARITY_EN is defined.

Behaviour:
- Reset (sampled on the clk edge with rst=1):
  - databus=8'h00, rda=0, overrun=0, frame_err=0, parity_err=0.
  - FSM goes to IDLE; synchronizer flops are set to 1.
  - A frame in progress is discarded. Reset overrides rd_ack.
- Input sync: rxd passes through a 2-flop synchronizer to give rxd_s. All decisions use rxd_s.
- Baud tick:
  - Counter counts DIVISOR-1 down to 0; tick=1 for one clk when it reaches 0, then it reloads.
  - The counter and the 4-bit sample counter reload to 0 on the IDLE->START transition, so bit timing is phase-locked to the start edge.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE: wait for rxd_s=0, then go to START.
  - START: on the 8th tick (mid start bit), re-sample rxd_s.
    - rxd_s=1 is a false start: return to IDLE with no flag change.
    - rxd_s=0: clear the sample and bit counters, go to DATA.
  - DATA: every 16th tick, shift rxd_s into shift[7] (right-shift, so LSB is received first). After 8 bits go to STOP (or PARITY).
  - STOP: on the 16th tick, sample rxd_s, then return to IDLE.
    - Sample=1: databus<=shift and rda<=1 on the next clk edge.
    - Sample=0: frame_err<=1; databus and rda unchanged.
- Latency: rda rises exactly 1 clk after the stop-bit sampling tick. databus is stable whenever rda=1.
- rda and overrun handling:
  - rd_ack with no completion: rda, overrun, frame_err and parity_err go to 0 next cycle.
  - Completion while rda=1 and no rd_ack: databus is overwritten, rda stays 1, overrun<=1.
  - Completion in the same cycle as rd_ack: the new byte wins. rda=1, overrun=0, error flags cleared. The new byte's own errors are recorded; new errors have priority over the clear.
  - rd_ack while rda=0: no effect except clearing the sticky flags.
- A break (rxd held low): produces one frame_err, then the block waits in IDLE for rxd_s=1 before re-arming start detection. IDLE requires rxd_s=1 for at least one tick before accepting a new start.
- Back-to-back frames: a start bit immediately following the stop sample is accepted.

Optional Feature:
- Macro: SPART_PARITY_EN.
- Defined:
  - Frame is 8E1. PARITY state samples a 9th bit on the 16th tick.
  - Even parity mismatch sets parity_err (sticky), but the byte is still delivered if the stop bit is good.
- Undefined:
  - 8N1 framing only. PARITY state and parity logic are absent; parity_err is tied to 0.

Test Plan:
- Reset then idle line, DIVISOR=4 (bit period 64 clk): outputs stay databus=00, rda=0, overrun=frame_err=parity_err=0.
- Send 8'h77 ('w') 8N1: rda=1 exactly 1 clk after the stop sample with databus=77. Pulse rd_ack: rda=0 next clk, databus holds 77.
- Send 8'h4A then 8'h61 with no rd_ack: rda stays 1, databus=61, overrun=1. rd_ack clears overrun and rda.
- 16-clk low glitch on rxd (shorter than half a bit): false start rejected, FSM back in IDLE, no flag changes. Then send 8'h53: databus=53 received correctly.
- Send 8'h64 with the stop bit driven 0: frame_err=1, rda=0, databus unchanged. Assert rst mid-frame on the next byte: all outputs reset, and the following 8'h44 frame is received cleanly.
- With SPART_PARITY_EN: 8'h73 with correct even parity bit (1) gives parity_err=0. Wrong parity bit (0) gives databus=73, rda=1, parity_err=1. rd_ack coincident with a completing byte leaves rda=1, overrun=0.
